shift_sequencer: RTL and testbench

//   Multi-cycle shift unit controller for the MIPS-32 datapath. Executes SLL/SRL/SRA by
//   a variable amount and LUI (fixed left shift by WIDTH/2). It decomposes the shift

---
 rtl/shift_sequencer_pkg.sv | 22 ++
 rtl/shift_step.sv | 25 ++
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared opcodes, FSM states and step-size selects for the multi-cycle shift unit.
// Step selects map to 16/4/1-bit shifts sized for a 32-bit datapath.
package shift_sequencer_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_LUI = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      STEP1  = 2'd0,
      STEP4  = 2'd1,
      STEP16 = 2'd2
   } step_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts value by 16, 4 or 1 bit, left or right.
// Zero latency; right shifts insert the supplied fill bit, left shifts insert zeros.
module shift_step
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             dir,
   input  step_t            sel,
   input  logic             fill,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = value;
      case (sel)
         STEP16:  shifted = dir ? {{16{fill}}, value[WIDTH-1:16]} : {value[WIDTH-17:0], 16'b0};
         STEP4:   shifted = dir ? {{4{fill}},  value[WIDTH-1:4]}  : {value[WIDTH-5:0],  4'b0};
         STEP1:   shifted = dir ? {fill,       value[WIDTH-1:1]}  : {value[WIDTH-2:0],  1'b0};
         default: shifted = value;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// SLL/SRL/SRA/LUI sequencer: one 16/4/1-bit step per clock, done pulses 1+steps cycles after start.
// No backpressure: start is sampled only in IDLE; result holds until the next operation completes.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   state_t             state, state_nx;
   logic [WIDTH-1:0]   work, stepped;
   logic [SHAMT_W-1:0] rem, rem_nx, step_amt, n_eff;
   logic               dir, fill;
   step_t              sel;

   assign n_eff = (op == OP_LUI) ? SHAMT_W'(WIDTH/2) : shamt;

   // Largest step not exceeding rem, so rem can never underflow.
   always_comb begin
      sel      = STEP1;
      step_amt = SHAMT_W'(1);
      if (rem >= SHAMT_W'(16)) begin
         sel      = STEP16;
         step_amt = SHAMT_W'(16);
      end else if (rem >= SHAMT_W'(4)) begin
         sel      = STEP4;
         step_amt = SHAMT_W'(4);
      end
   end

   assign rem_nx = rem - step_amt;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .value   (work),
      .dir     (dir),
      .sel     (sel),
      .fill    (fill),
      .shifted (stepped)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (n_eff == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (rem_nx == '0) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Fill is captured from the original operand so SRA sign survives every step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work   <= '0;
         rem    <= '0;
         dir    <= 1'b0;
         fill   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  work <= data;
                  rem  <= n_eff;
                  dir  <= (op == OP_SRL) || (op == OP_SRA);
                  fill <= (op == OP_SRA) && data[WIDTH-1];
                  if (n_eff == '0) begin
                     result <= data;
                  end
               end
            end
            S_SHIFT: begin
               work <= stepped;
               rem  <= rem_nx;
               if (rem_nx == '0) begin
                  result <= stepped;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed cases then random traffic against an arithmetic model.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [4:0]  shamt = 5'd0;
   logic [31:0] data = 32'd0;
   logic        busy, done;
   logic [31:0] result;

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .shamt  (shamt),
      .data   (data),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          free_cyc = 0;
   int          busy_lo = 0;
   int          busy_hi = -1;
   logic [31:0] hold = 32'd0;
   int          nchk = 0;
   int          nerr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s cyc=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input int n, input logic [31:0] d);
      logic [31:0] e;
      case (o)
         2'b00:   e = d << n;
         2'b01:   e = d >> n;
         2'b10:   e = $signed(d) >>> n;
         default: e = d << 16;
      endcase
      return e;
   endfunction

   // One cycle of stimulus; the model decides whether the DUT will accept it.
   task automatic drive(input logic s, input logic [1:0] o, input logic [4:0] sh, input logic [31:0] d);
      int   n, steps;
      exp_t e;
      @(posedge clk);
      #1;
      start = s;
      op    = o;
      shamt = sh;
      data  = d;
      if (s && cyc >= free_cyc) begin
         n       = (o == 2'b11) ? 16 : int'(sh);
         steps   = n / 16 + (n % 16) / 4 + n % 4;
         e.res   = model(o, n, d);
         e.cyc   = cyc + 1 + steps;
         q.push_back(e);
         busy_lo  = cyc + 1;
         busy_hi  = cyc + 1 + steps;
         free_cyc = cyc + 2 + steps;
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive(1'b0, 2'b00, 5'd0, 32'd0);
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      reset = 1'b1;
      start = 1'b0;
      q.delete();
      busy_hi = -1;
      hold    = 32'd0;
      #1;
      check(busy == 1'b0, "reset_busy", {31'd0, busy}, 32'd0);
      check(done == 1'b0, "reset_done", {31'd0, done}, 32'd0);
      check(result == 32'd0, "reset_result", result, 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      free_cyc = cyc + 1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         check(busy == ((cyc >= busy_lo) && (cyc <= busy_hi)), "busy",
               {31'd0, busy}, {31'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
         if (done) begin
            if (q.size() == 0) begin
               check(1'b0, "spurious_done", {31'd0, done}, 32'd0);
            end else begin
               e = q.pop_front();
               check(cyc == e.cyc, "done_cycle", cyc, e.cyc);
               check(result == e.res, "result", result, e.res);
               hold = e.res;
            end
         end else begin
            if (q.size() != 0 && q[0].cyc == cyc) begin
               e = q.pop_front();
               check(1'b0, "missed_done", {31'd0, done}, 32'd1);
            end
            check(result == hold, "result_hold", result, hold);
         end
      end
   end

   initial begin
      #2;
      check(busy == 1'b0, "init_busy", {31'd0, busy}, 32'd0);
      check(done == 1'b0, "init_done", {31'd0, done}, 32'd0);
      check(result == 32'd0, "init_result", result, 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      free_cyc = cyc;

      drive(1'b1, 2'b00, 5'd31, 32'h0000_0001);
      idle(9);
      drive(1'b1, 2'b10, 5'd4, 32'hF000_0000);
      idle(3);
      drive(1'b1, 2'b01, 5'd4, 32'hF000_0000);
      idle(3);
      drive(1'b1, 2'b11, 5'd7, 32'h0000_ABCD);
      idle(3);
      drive(1'b1, 2'b00, 5'd0, 32'h1234_5678);
      drive(1'b1, 2'b00, 5'd0, 32'h1234_5678);
      drive(1'b1, 2'b01, 5'd4, 32'h8765_4321);
      idle(4);
      drive(1'b1, 2'b01, 5'd21, 32'hFFFF_FFFF);
      idle(2);
      drive(1'b1, 2'b00, 5'd3, 32'h0000_00FF);
      idle(5);

      drive(1'b1, 2'b00, 5'd31, 32'hDEAD_BEEF);
      idle(2);
      do_reset();
      idle(1);
      drive(1'b1, 2'b10, 5'd17, 32'h8000_1234);
      idle(10);

      for (int i = 0; i < 1500; i++) begin
         logic [4:0] sh;
         case ($urandom_range(0, 5))
            0:       sh = 5'd0;
            1:       sh = 5'd31;
            default: sh = 5'($urandom_range(0, 31));
         endcase
         drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), sh, $urandom);
      end
      idle(1);

      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
      if (q.size() != 0) check(1'b0, "drain_timeout", q.size(), 32'd0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
